// File: rtl/ball_if.sv
// ball_if: game-side signal bundle between the paddle/serve source and the
// ball engine.
//   serve           source -> engine   single-cycle serve request
//   paddle_left_y   source -> engine   left paddle top y
//   paddle_right_y  source -> engine   right paddle top y
//   ball_x, ball_y  engine -> source   ball top-left position
//   left_edge       engine -> source   left-edge exit count
//   right_edge      engine -> source   right-edge exit count
//   in_play         engine -> source   high while the ball is in play
//   hit             engine -> source   one-cycle pulse per paddle bounce
interface ball_if;
  logic        serve;
  logic [9:0]  paddle_left_y;
  logic [9:0]  paddle_right_y;
  logic [9:0]  ball_x;
  logic [9:0]  ball_y;
  logic [31:0] left_edge;
  logic [31:0] right_edge;
  logic        in_play;
  logic        hit;

  modport master (
    output serve, paddle_left_y, paddle_right_y,
    input  ball_x, ball_y, left_edge, right_edge, in_play, hit
  );

  modport slave (
    input  serve, paddle_left_y, paddle_right_y,
    output ball_x, ball_y, left_edge, right_edge, in_play, hit
  );
endinterface

// File: rtl/ball_engine.sv
// ball_engine: moves a square ball across the playfield at a fixed step rate,
// bounces it off the top/bottom walls and both paddles, and counts exits
// through the left and right edges.
// Ports:
//   clock  system clock
//   reset  asynchronous, active-high reset
//   bus    ball_if.slave (serve/paddle inputs, ball/edge/status outputs)
//
// state      | meaning
// -----------+-----------------------------------------------
// SERVE_WAIT | ball parked at center, waiting for serve pulse
// PLAY       | ball moving, one move per step tick
// POINT      | ball frozen after an exit for HOLD_STEPS steps
module ball_engine #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_SIZE   = 8,
  parameter int PADDLE_H    = 64,
  parameter int PADDLE_W    = 8,
  parameter int PADDLE_X_L  = 16,
  parameter int PADDLE_X_R  = 616,
  parameter int SPEED       = 2,
  parameter int STEP_CYCLES = 416667,
  parameter int HOLD_STEPS  = 60
) (
  input logic   clock,
  input logic   reset,
  ball_if.slave bus
);

  typedef enum logic [1:0] {
    SERVE_WAIT = 2'd0,
    PLAY       = 2'd1,
    POINT      = 2'd2
  } state_t;

  localparam int CNT_W  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int HOLD_W = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;

  localparam logic [CNT_W-1:0]  STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_STEPS - 1);

  localparam logic [9:0] X_CENTER = 10'((SCREEN_W - BALL_SIZE) / 2);
  localparam logic [9:0] Y_CENTER = 10'((SCREEN_H - BALL_SIZE) / 2);

  // All motion math is 12-bit signed so nx/ny can go negative at the edges.
  localparam logic signed [11:0] S_SPEED  = 12'(SPEED);
  localparam logic signed [11:0] S_BALL   = 12'(BALL_SIZE);
  localparam logic signed [11:0] S_PH     = 12'(PADDLE_H);
  localparam logic signed [11:0] S_Y_MAX  = 12'(SCREEN_H - BALL_SIZE);
  localparam logic signed [11:0] S_X_MAX  = 12'(SCREEN_W - BALL_SIZE);
  localparam logic signed [11:0] S_L_FACE = 12'(PADDLE_X_L + PADDLE_W);
  localparam logic signed [11:0] S_R_FACE = 12'(PADDLE_X_R);
  localparam logic signed [11:0] S_ZERO   = 12'sd0;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    step_cnt_q;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [9:0]          ball_x_q, ball_x_d;
  logic [9:0]          ball_y_q, ball_y_d;
  logic                dx_neg_q, dx_neg_d;
  logic                dy_neg_q, dy_neg_d;
  logic                serve_right_q, serve_right_d;
  logic [31:0]         left_edge_q, left_edge_d;
  logic [31:0]         right_edge_q, right_edge_d;
  logic                hit_q, hit_d;

  logic                step;
  logic signed [11:0]  cur_x, cur_y, dx, dy, nx, ny, pl, pr;
  logic                ov_l, ov_r;

  // Free-running step timer; runs in every state so step phase never drifts.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_cnt_q <= '0;
    end else if (step_cnt_q == STEP_LAST) begin
      step_cnt_q <= '0;
    end else begin
      step_cnt_q <= step_cnt_q + 1'b1;
    end
  end

  assign step = (step_cnt_q == STEP_LAST);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= SERVE_WAIT;
      hold_q        <= '0;
      ball_x_q      <= X_CENTER;
      ball_y_q      <= Y_CENTER;
      dx_neg_q      <= 1'b0;
      dy_neg_q      <= 1'b0;
      serve_right_q <= 1'b0;
      left_edge_q   <= '0;
      right_edge_q  <= '0;
      hit_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_q        <= hold_d;
      ball_x_q      <= ball_x_d;
      ball_y_q      <= ball_y_d;
      dx_neg_q      <= dx_neg_d;
      dy_neg_q      <= dy_neg_d;
      serve_right_q <= serve_right_d;
      left_edge_q   <= left_edge_d;
      right_edge_q  <= right_edge_d;
      hit_q         <= hit_d;
    end
  end

  always_comb begin
    cur_x = $signed({2'b00, ball_x_q});
    cur_y = $signed({2'b00, ball_y_q});
    dx    = dx_neg_q ? -S_SPEED : S_SPEED;
    dy    = dy_neg_q ? -S_SPEED : S_SPEED;
    nx    = cur_x + dx;
    ny    = cur_y + dy;
    // Paddle y is taken as-is (no clamping), so the full 10-bit range is legal.
    pl    = $signed({2'b00, bus.paddle_left_y});
    pr    = $signed({2'b00, bus.paddle_right_y});
    ov_l  = (cur_y + S_BALL > pl) && (cur_y < pl + S_PH);
    ov_r  = (cur_y + S_BALL > pr) && (cur_y < pr + S_PH);
  end

  always_comb begin
    state_d       = state_q;
    hold_d        = hold_q;
    ball_x_d      = ball_x_q;
    ball_y_d      = ball_y_q;
    dx_neg_d      = dx_neg_q;
    dy_neg_d      = dy_neg_q;
    serve_right_d = serve_right_q;
    left_edge_d   = left_edge_q;
    right_edge_d  = right_edge_q;
    hit_d         = 1'b0;

    case (state_q)
      SERVE_WAIT: begin
        if (bus.serve) begin
          state_d = PLAY;
        end
      end

      PLAY: begin
        if (step) begin
          if (ny <= S_ZERO) begin
            ball_y_d = 10'd0;
            dy_neg_d = 1'b0;
          end else if (ny >= S_Y_MAX) begin
            ball_y_d = S_Y_MAX[9:0];
            dy_neg_d = 1'b1;
          end else begin
            ball_y_d = ny[9:0];
          end

          // Paddle bounces are checked before exits so a hit wins over an exit.
          if (dx_neg_q && (cur_x >= S_L_FACE) && (nx < S_L_FACE) && ov_l) begin
            ball_x_d = S_L_FACE[9:0];
            dx_neg_d = 1'b0;
            hit_d    = 1'b1;
          end else if (!dx_neg_q && (cur_x + S_BALL <= S_R_FACE) &&
                       (nx + S_BALL > S_R_FACE) && ov_r) begin
            ball_x_d = 10'(S_R_FACE - S_BALL);
            dx_neg_d = 1'b1;
            hit_d    = 1'b1;
          end else if (nx <= S_ZERO) begin
            ball_x_d      = 10'd0;
            left_edge_d   = left_edge_q + 32'd1;
            serve_right_d = 1'b0;
            state_d       = POINT;
          end else if (nx >= S_X_MAX) begin
            ball_x_d      = S_X_MAX[9:0];
            right_edge_d  = right_edge_q + 32'd1;
            serve_right_d = 1'b1;
            state_d       = POINT;
          end else begin
            ball_x_d = nx[9:0];
          end
        end
      end

      POINT: begin
        if (step) begin
          if (hold_q == HOLD_LAST) begin
            hold_d   = '0;
            ball_x_d = X_CENTER;
            ball_y_d = Y_CENTER;
            // Ball heads back toward the side that just scored against.
            dx_neg_d = !serve_right_q;
            dy_neg_d = 1'b0;
            state_d  = SERVE_WAIT;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = SERVE_WAIT;
      end
    endcase
  end

  assign bus.ball_x     = ball_x_q;
  assign bus.ball_y     = ball_y_q;
  assign bus.left_edge  = left_edge_q;
  assign bus.right_edge = right_edge_q;
  assign bus.in_play    = (state_q == PLAY);
  assign bus.hit        = hit_q;

endmodule
